// File: rtl/safe_pkg.sv
// Shared definitions for the safe's code writer and comparator: FSM states and
// the factory code loaded at reset.
package safe_pkg;

   typedef enum logic [2:0] {
      IDLE,
      AUTH,
      NEW1,
      NEW2,
      LOCK
   } safe_state_t;

   localparam logic [3:0] SAFE_RESET_CODE = 4'b1100;

endpackage

// File: rtl/safe_cycle_counter.sv
// Down-counter that reports expiry after CYC enabled cycles following a load.
// Used for the lockout window and, optionally, the idle-entry timeout.
module safe_cycle_counter #(
   parameter int CYC = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic expired
);

   localparam int W = (CYC > 1) ? $clog2(CYC) : 1;

   logic [W-1:0] count;

   // Load wins over enable so a fresh window always starts from the full count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= W'(CYC - 1);
      end else if (load) begin
         count <= W'(CYC - 1);
      end else if (en && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/safe_code_writer.sv
// Programming side of the safe's code comparator: authenticates, double-confirms and
// commits a new stored code. Optional idle-entry timeout via SAFE_ENTRY_TIMEOUT_EN.
module safe_code_writer
   import safe_pkg::*;
#(
   parameter int                CODE_W      = 4,
   parameter logic [CODE_W-1:0] RESET_CODE  = CODE_W'(SAFE_RESET_CODE),
   parameter int                MAX_FAIL    = 3,
   parameter int                LOCKOUT_CYC = 16
`ifdef SAFE_ENTRY_TIMEOUT_EN
   ,
   parameter int                TIMEOUT_CYC = 64
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              prog_req,
   input  logic              key_valid,
   input  logic [CODE_W-1:0] key_data,
   output logic              key_ready,
   output logic [CODE_W-1:0] code_out,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              locked_out
);

   localparam int FAIL_W = (MAX_FAIL > 0) ? $clog2(MAX_FAIL + 1) : 1;

   safe_state_t       state, state_next;
   logic [FAIL_W-1:0] fail_cnt, fail_next, fail_inc;
   logic [CODE_W-1:0] new_tmp, new_next, code_next;
   logic              done_next, err_next;
   logic              xfer, lock_expired, timeout_hit;

   // key_ready mirrors "state is AUTH/NEW1/NEW2", so it doubles as the entry-state flag.
   assign xfer     = key_valid && key_ready;
   assign fail_inc = (fail_cnt == FAIL_W'(MAX_FAIL)) ? fail_cnt : fail_cnt + FAIL_W'(1);

   safe_cycle_counter #(.CYC(LOCKOUT_CYC)) u_lockout (
      .clk     (clk),
      .rst     (rst),
      .load    (state != LOCK),
      .en      (state == LOCK),
      .expired (lock_expired)
   );

`ifdef SAFE_ENTRY_TIMEOUT_EN
   logic tmo_expired;

   safe_cycle_counter #(.CYC(TIMEOUT_CYC)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .load    (!key_ready || xfer),
      .en      (key_ready),
      .expired (tmo_expired)
   );

   assign timeout_hit = tmo_expired;
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_next = state;
      fail_next  = fail_cnt;
      code_next  = code_out;
      new_next   = new_tmp;
      done_next  = 1'b0;
      err_next   = 1'b0;
      case (state)
         IDLE: begin
            if (prog_req) state_next = AUTH;
         end
         AUTH: begin
            if (xfer) begin
               if (key_data == code_out) begin
                  fail_next  = '0;
                  state_next = NEW1;
               end else begin
                  fail_next  = fail_inc;
                  err_next   = 1'b1;
                  state_next = (fail_inc == FAIL_W'(MAX_FAIL)) ? LOCK : IDLE;
               end
            end else if (timeout_hit) begin
               err_next   = 1'b1;
               state_next = IDLE;
            end
         end
         NEW1: begin
            if (xfer) begin
               new_next   = key_data;
               state_next = NEW2;
            end else if (timeout_hit) begin
               err_next   = 1'b1;
               state_next = IDLE;
            end
         end
         NEW2: begin
            if (xfer) begin
               if (key_data == new_tmp) begin
                  code_next = new_tmp;
                  done_next = 1'b1;
               end else begin
                  err_next  = 1'b1;
               end
               state_next = IDLE;
            end else if (timeout_hit) begin
               err_next   = 1'b1;
               state_next = IDLE;
            end
         end
         LOCK: begin
            if (lock_expired) begin
               fail_next  = '0;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         fail_cnt   <= '0;
         code_out   <= RESET_CODE;
         new_tmp    <= '0;
         key_ready  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         locked_out <= 1'b0;
      end else begin
         state      <= state_next;
         fail_cnt   <= fail_next;
         code_out   <= code_next;
         new_tmp    <= new_next;
         key_ready  <= (state_next == AUTH) || (state_next == NEW1) || (state_next == NEW2);
         busy       <= (state_next != IDLE);
         done       <= done_next;
         err        <= err_next;
         locked_out <= (state_next == LOCK);
      end
   end

endmodule

// File: tb/tb_safe_code_writer.sv
// Self-checking bench for safe_code_writer: directed scenarios plus randomized
// programming sequences scored against a sequence-level model of the safe.
module tb_safe_code_writer;

   localparam int MAX_FAIL    = 3;
   localparam int LOCKOUT_CYC = 16;
   localparam int TIMEOUT_CYC = 64;
   localparam logic [3:0] FACTORY_CODE = 4'b1100;

   logic       clk = 1'b0;
   logic       rst;
   logic       prog_req;
   logic       key_valid;
   logic [3:0] key_data;
   logic       key_ready;
   logic [3:0] code_out;
   logic       busy;
   logic       done;
   logic       err;
   logic       locked_out;

   int checkCount = 0;
   int passCount  = 0;

   logic [3:0] modelCode;
   int         modelFails;

   safe_code_writer dut (
      .clk        (clk),
      .rst        (rst),
      .prog_req   (prog_req),
      .key_valid  (key_valid),
      .key_data   (key_data),
      .key_ready  (key_ready),
      .code_out   (code_out),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .locked_out (locked_out)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got === exp) passCount++;
      else $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic gap(input int n);
      key_valid = 1'b0;
      repeat (n) begin
         key_data = 4'($urandom);
         tick();
      end
   endtask

   // prog_req is waved around during transfers; it must be ignored outside IDLE.
   task automatic sendKey(input logic [3:0] k);
      key_valid = 1'b1;
      key_data  = k;
      prog_req  = 1'($urandom);
      tick();
      key_valid = 1'b0;
      prog_req  = 1'b0;
   endtask

   task automatic expectLockout();
      for (int i = 0; i < LOCKOUT_CYC; i++) begin
         checkOutput("lock_flag", locked_out, 1);
         checkOutput("lock_ready", key_ready, 0);
         checkOutput("lock_code", code_out, modelCode);
         if (i > 0) checkOutput("lock_err", err, 0);
         key_valid = 1'($urandom);
         key_data  = 4'($urandom);
         prog_req  = 1'($urandom);
         tick();
      end
      key_valid = 1'b0;
      prog_req  = 1'b0;
      checkOutput("lock_exit", locked_out, 0);
      checkOutput("lock_exit_busy", busy, 0);
      checkOutput("lock_exit_err", err, 0);
      modelFails = 0;
   endtask

   // One full programming attempt: authenticate with a, then enter n1 and n2.
   task automatic applyStimulus(input logic [3:0] a, input logic [3:0] n1, input logic [3:0] n2);
      int idleLen;
      idleLen = $urandom_range(0, 3);
      for (int i = 0; i < idleLen; i++) begin
         key_valid = 1'($urandom);
         key_data  = 4'($urandom);
         tick();
         checkOutput("idle_busy", busy, 0);
         checkOutput("idle_ready", key_ready, 0);
      end
      key_valid = 1'b0;
      prog_req  = 1'b1;
      tick();
      prog_req  = 1'b0;
      checkOutput("auth_ready", key_ready, 1);
      checkOutput("auth_busy", busy, 1);
      gap($urandom_range(0, 4));
      sendKey(a);
      if (a != modelCode) begin
         if (modelFails < MAX_FAIL) modelFails++;
         checkOutput("auth_err", err, 1);
         checkOutput("auth_done", done, 0);
         checkOutput("auth_code", code_out, modelCode);
         if (modelFails == MAX_FAIL) begin
            expectLockout();
         end else begin
            checkOutput("fail_busy", busy, 0);
            checkOutput("fail_lock", locked_out, 0);
         end
         return;
      end
      modelFails = 0;
      checkOutput("auth_ok_err", err, 0);
      checkOutput("auth_ok_ready", key_ready, 1);
      gap($urandom_range(0, 4));
      sendKey(n1);
      checkOutput("new1_busy", busy, 1);
      checkOutput("new1_pulse", {done, err}, 0);
      checkOutput("new1_code", code_out, modelCode);
      gap($urandom_range(0, 4));
      sendKey(n2);
      if (n1 == n2) begin
         modelCode = n1;
         checkOutput("commit_done", done, 1);
         checkOutput("commit_err", err, 0);
      end else begin
         checkOutput("confirm_err", err, 1);
         checkOutput("confirm_done", done, 0);
      end
      checkOutput("end_code", code_out, modelCode);
      checkOutput("end_busy", busy, 0);
      tick();
      checkOutput("pulse_len", {done, err}, 0);
   endtask

   task automatic resetMidNew2();
      prog_req = 1'b1;
      tick();
      prog_req = 1'b0;
      sendKey(modelCode);
      sendKey(4'b0011);
      checkOutput("pre_rst_busy", busy, 1);
      rst = 1'b1;
      #1;
      checkOutput("rst_code", code_out, FACTORY_CODE);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_ready", key_ready, 0);
      tick();
      rst = 1'b0;
      modelCode  = FACTORY_CODE;
      modelFails = 0;
   endtask

   initial begin
      rst       = 1'b1;
      prog_req  = 1'b0;
      key_valid = 1'b0;
      key_data  = 4'h0;
      modelCode  = FACTORY_CODE;
      modelFails = 0;
      repeat (2) tick();
      checkOutput("reset_code", code_out, FACTORY_CODE);
      checkOutput("reset_flags", {busy, key_ready, done, err, locked_out}, 0);
      rst = 1'b0;
      tick();
      checkOutput("post_reset_flags", {busy, key_ready, done, err, locked_out}, 0);

      applyStimulus(4'b1100, 4'b0101, 4'b0110);
      applyStimulus(4'b1100, 4'b0101, 4'b0101);
      checkOutput("commit_0101", code_out, 4'b0101);
      resetMidNew2();
      applyStimulus(4'b0000, 4'h0, 4'h0);
      applyStimulus(4'b0000, 4'h0, 4'h0);
      applyStimulus(4'b0000, 4'h0, 4'h0);
      applyStimulus(4'b1100, 4'b0011, 4'b0011);
      checkOutput("post_lock_commit", code_out, 4'b0011);
      applyStimulus(4'b0011, 4'b0011, 4'b0011);

`ifdef SAFE_ENTRY_TIMEOUT_EN
      prog_req = 1'b1;
      tick();
      prog_req = 1'b0;
      for (int i = 1; i < TIMEOUT_CYC; i++) begin
         key_data = 4'($urandom);
         tick();
         checkOutput("tmo_wait_err", err, 0);
         checkOutput("tmo_wait_busy", busy, 1);
      end
      tick();
      checkOutput("tmo_err", err, 1);
      checkOutput("tmo_busy", busy, 0);
      checkOutput("tmo_code", code_out, modelCode);
`endif

      for (int n = 0; n < 40; n++) begin
         logic [3:0] a, n1, n2;
         a  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : modelCode;
         n1 = 4'($urandom);
         n2 = ($urandom_range(0, 2) == 0) ? 4'($urandom) : n1;
         applyStimulus(a, n1, n2);
      end

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
